morse_beep_sequencer: RTL and testbench
=======================================

MORSE_BEEP_SEQUENCER -- requirements
Module: morse_beep_sequencer

Interface
REQ-001 SHALL have parameter UNIT_CYCLES, default 12500000: clk cycles per Morse time unit.
REQ-002 SHALL have parameter TONE_HALF, default 50000: clk cycles per half-period of the dot tone.
REQ-003 SHALL have parameter TONE_HALF_DASH, default 100000: clk cycles per half-period of the dash tone (used only under DASH_TONE_EN).
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port sym_valid  input  1  upstream offers a symbol.
REQ-007 SHALL have port sym_code  input  2  symbol: 00 dot, 01 dash, 10 letter gap, 11 word gap.
REQ-008 SHALL have port sym_ready  output  1  block accepts a symbol this cycle.
REQ-009 SHALL have port tone_tick  output  1  one-cycle pulse per tone half-period; drives the buzzer's toggle-clock input.
REQ-010 SHALL have port tone_on  output  1  high for the whole mark (sounding) interval.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, MARK, SPACE.
REQ-013 SHALL drive sym_ready = (state==IDLE) and not rst; a transfer occurs on a cycle with sym_valid and sym_ready both high.
REQ-014 On a transfer of dot/dash, SHALL enter MARK the next cycle for 1 unit (dot) or 3 units (dash), then SPACE for 1 unit, then IDLE.
REQ-015 On a transfer of letter gap/word gap, SHALL enter SPACE directly for 2 units or 6 units, then IDLE; tone_on stays 0.
REQ-016 Each unit SHALL last exactly UNIT_CYCLES cycles; a dot mark is therefore exactly UNIT_CYCLES cycles of tone_on=1.
REQ-017 SHALL hold exactly one IDLE cycle between consecutive symbols; sym_valid held high yields back-to-back symbols separated only by that cycle.
REQ-018 tone_on SHALL be registered, high exactly in MARK cycles.
REQ-019 In MARK, the half-period counter SHALL clear on MARK entry and pulse tone_tick on its count TONE_HALF-1, then wrap to 0; tone_tick SHALL be 0 outside MARK.
REQ-020 A partial half-period at mark end SHALL be discarded (no tick emitted on the SPACE transition).
REQ-021 sym_code SHALL be sampled only on a transfer; changes while busy SHALL be ignored.
REQ-022 Unit and cycle counters SHALL be 32 bits; parameters less than 2 are unsupported.

Reset
REQ-023 While rst is high: state IDLE, all counters 0, tone_on 0, tone_tick 0, busy 0, sym_ready 0.
REQ-024 rst asserted mid-MARK or mid-SPACE SHALL abort the symbol with no further tick; first cycle after rst release SHALL show sym_ready 1.

Configuration
REQ-025 Macro DASH_TONE_EN defined: dash marks SHALL use TONE_HALF_DASH as half-period; dot marks use TONE_HALF.
REQ-026 DASH_TONE_EN undefined: all marks SHALL use TONE_HALF; TONE_HALF_DASH unused.

Structure
REQ-027 Package morse_pkg SHALL hold the sym_code encoding constants, the FSM state enum, and the unit-count constants (1, 3, 1, 2, 6).
REQ-028 Sub-module tone_divider SHALL contain the half-period counter (inputs clk, rst, enable, half-period value; output tick).

Verification (UNIT_CYCLES=20, TONE_HALF=4, TONE_HALF_DASH=8)
REQ-029 Reset then one dot -> tone_on high 20 cycles, 5 tone_tick pulses 4 cycles apart, then 20 SPACE cycles, then sym_ready 1.
REQ-030 One dash -> tone_on high 60 cycles; 15 ticks without DASH_TONE_EN, 7 ticks 8 cycles apart with DASH_TONE_EN.
REQ-031 Letter gap then word gap back-to-back with sym_valid held -> busy 40 cycles, 1 IDLE cycle, busy 120 cycles, tone_on never high.
REQ-032 sym_code changed while busy during a dot -> mark length stays 20 cycles.
REQ-033 rst pulsed at cycle 10 of a dash mark -> tone_on and tone_tick 0 from the next edge, sym_ready 1 on the cycle after rst release.
REQ-034 sym_valid low indefinitely -> state remains IDLE, sym_ready 1, tone_tick never asserted.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared encodings and unit-count constants for the Morse beep sequencer.
package morse_pkg;

  localparam logic [1:0] SYM_DOT    = 2'b00;
  localparam logic [1:0] SYM_DASH   = 2'b01;
  localparam logic [1:0] SYM_LETTER = 2'b10;
  localparam logic [1:0] SYM_WORD   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } state_t;

  localparam logic [31:0] UNITS_DOT    = 32'd1;
  localparam logic [31:0] UNITS_DASH   = 32'd3;
  localparam logic [31:0] UNITS_SPACE  = 32'd1;
  localparam logic [31:0] UNITS_LETTER = 32'd2;
  localparam logic [31:0] UNITS_WORD   = 32'd6;

  // Length of the first interval entered after accepting a symbol.
  function automatic logic [31:0] units_for(input logic [1:0] code);
    case (code)
      SYM_DOT:    return UNITS_DOT;
      SYM_DASH:   return UNITS_DASH;
      SYM_LETTER: return UNITS_LETTER;
      default:    return UNITS_WORD;
    endcase
  endfunction

endpackage

// File: rtl/tone_divider.sv
// Half-period counter: one-cycle tick every `half` enabled cycles, cleared whenever disabled.
module tone_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] half,
  output logic        tick
);

  logic [31:0] cnt;
  logic        wrap;

  assign wrap = (cnt == half - 32'd1);
  assign tick = enable && wrap;

  always_ff @(posedge clk) begin
    if (rst || !enable) cnt <= '0;
    else if (wrap)      cnt <= '0;
    else                cnt <= cnt + 32'd1;
  end

endmodule

// File: rtl/morse_beep_sequencer.sv
// Morse symbol sequencer: accepts dot/dash/gap symbols, times mark and space intervals,
// and emits tone toggle ticks. Define DASH_TONE_EN to give dashes their own tone pitch.
module morse_beep_sequencer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES    = 12500000,
  parameter int TONE_HALF      = 50000,
  parameter int TONE_HALF_DASH = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sym_valid,
  input  logic [1:0] sym_code,
  output logic       sym_ready,
  output logic       tone_tick,
  output logic       tone_on,
  output logic       busy
);

  localparam logic [31:0] UNIT_M1 = 32'(UNIT_CYCLES - 1);

  state_t      state, state_n;
  logic [31:0] cyc_cnt, unit_cnt, units, units_n;
  logic [31:0] half;
  logic        xfer, last, dash_sel;

  assign sym_ready = (state == IDLE) && !rst;
  assign busy      = (state != IDLE) && !rst;
  assign xfer      = sym_valid && sym_ready;
  assign last      = (cyc_cnt == UNIT_M1) && (unit_cnt == units - 32'd1);

  always_comb begin
    state_n = state;
    units_n = units;
    case (state)
      IDLE: if (xfer) begin
        units_n = units_for(sym_code);
        state_n = sym_code[1] ? SPACE : MARK;
      end
      MARK: if (last) begin
        state_n = SPACE;
        units_n = UNITS_SPACE;
      end
      SPACE: if (last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Counters restart on every state change, so each interval starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      units    <= '0;
      cyc_cnt  <= '0;
      unit_cnt <= '0;
      tone_on  <= 1'b0;
    end else begin
      state   <= state_n;
      units   <= units_n;
      tone_on <= (state_n == MARK);
      if (state_n != state) begin
        cyc_cnt  <= '0;
        unit_cnt <= '0;
      end else if (state != IDLE) begin
        if (cyc_cnt == UNIT_M1) begin
          cyc_cnt  <= '0;
          unit_cnt <= unit_cnt + 32'd1;
        end else begin
          cyc_cnt <= cyc_cnt + 32'd1;
        end
      end
    end
  end

`ifdef DASH_TONE_EN
  logic is_dash;
  always_ff @(posedge clk) begin
    if (rst)       is_dash <= 1'b0;
    else if (xfer) is_dash <= (sym_code == SYM_DASH);
  end
  assign dash_sel = is_dash;
`else
  assign dash_sel = 1'b0;
`endif

  assign half = dash_sel ? 32'(TONE_HALF_DASH) : 32'(TONE_HALF);

  tone_divider u_div (
    .clk    (clk),
    .rst    (rst),
    .enable ((state == MARK) && !rst),
    .half   (half),
    .tick   (tone_tick)
  );

endmodule

// File: tb/tb_morse_beep_sequencer.sv
// Randomized self-checking bench; expectations come from symbol timing arithmetic.
module tb_morse_beep_sequencer;

  localparam int UC  = 20;
  localparam int TH  = 4;
  localparam int THD = 8;
`ifdef DASH_TONE_EN
  localparam bit DASH_EN = 1'b1;
`else
  localparam bit DASH_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sym_valid = 1'b0;
  logic [1:0] sym_code = 2'b00;
  logic       sym_ready, tone_tick, tone_on, busy;

  int n_checks = 0;
  int n_pass   = 0;

  morse_beep_sequencer #(.UNIT_CYCLES(UC), .TONE_HALF(TH), .TONE_HALF_DASH(THD)) dut (
    .clk       (clk),
    .rst       (rst),
    .sym_valid (sym_valid),
    .sym_code  (sym_code),
    .sym_ready (sym_ready),
    .tone_tick (tone_tick),
    .tone_on   (tone_on),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference model: symbol lengths in cycles.
  function automatic int mark_len(input logic [1:0] c);
    case (c)
      2'b00:   return 1 * UC;
      2'b01:   return 3 * UC;
      default: return 0;
    endcase
  endfunction

  function automatic int busy_len(input logic [1:0] c);
    case (c)
      2'b00, 2'b01: return mark_len(c) + UC;
      2'b10:        return 2 * UC;
      default:      return 6 * UC;
    endcase
  endfunction

  function automatic int half_for(input logic [1:0] c);
    return (DASH_EN && c == 2'b01) ? THD : TH;
  endfunction

  // Issue one symbol from an idle negedge, observe it to completion.
  // mode 0: drop valid after transfer; 1: hold valid and scramble code; 2: random valid/code.
  task automatic play(input logic [1:0] code, input int mode);
    int mk, bl, hf, t, ntone, nticks, tickerr, toneerr, rdyerr;
    bit exp_tone, exp_tick;
    mk = mark_len(code); bl = busy_len(code); hf = half_for(code);
    t = 0; ntone = 0; nticks = 0; tickerr = 0; toneerr = 0; rdyerr = 0;
    sym_valid = 1'b1;
    sym_code  = code;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL xfer_latency code=%0d busy=%b want 1", code, busy);
    else n_pass++;
    while (busy === 1'b1 && t < 400) begin
      exp_tone = (t < mk);
      exp_tick = (t < mk) && ((t + 1) % hf == 0);
      if (tone_on !== exp_tone) toneerr++;
      if (tone_tick !== exp_tick) tickerr++;
      if (tone_on === 1'b1) ntone++;
      if (tone_tick === 1'b1) nticks++;
      if (sym_ready !== 1'b0) rdyerr++;
      t++;
      case (mode)
        0:       sym_valid = 1'b0;
        1:       sym_valid = 1'b1;
        default: sym_valid = 1'($urandom_range(0, 1));
      endcase
      if (mode != 0) sym_code = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    n_checks++;
    if (t !== bl) $display("FAIL busy_len code=%0d got %0d want %0d", code, t, bl);
    else n_pass++;
    n_checks++;
    if (ntone !== mk) $display("FAIL mark_len code=%0d got %0d want %0d", code, ntone, mk);
    else n_pass++;
    n_checks++;
    if (nticks !== mk / hf) $display("FAIL tick_count code=%0d got %0d want %0d", code, nticks, mk / hf);
    else n_pass++;
    n_checks++;
    if (tickerr !== 0) $display("FAIL tick_timing code=%0d bad_cycles=%0d want 0", code, tickerr);
    else n_pass++;
    n_checks++;
    if (toneerr !== 0) $display("FAIL tone_shape code=%0d bad_cycles=%0d want 0", code, toneerr);
    else n_pass++;
    n_checks++;
    if (rdyerr !== 0) $display("FAIL ready_while_busy code=%0d bad_cycles=%0d want 0", code, rdyerr);
    else n_pass++;
    n_checks++;
    if (sym_ready !== 1'b1 || tone_tick !== 1'b0)
      $display("FAIL idle_after code=%0d sym_ready=%b tick=%b want 1/0", code, sym_ready, tone_tick);
    else n_pass++;
    sym_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sym_valid = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({sym_ready, busy, tone_on, tone_tick} !== 4'b0000)
      $display("FAIL reset_outputs got ready/busy/tone/tick=%b want 0000",
               {sym_ready, busy, tone_on, tone_tick});
    else n_pass++;
    rst = 1'b0; sym_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (sym_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL reset_release ready=%b busy=%b want 1/0", sym_ready, busy);
    else n_pass++;
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    sym_valid = 1'b0;
    for (int i = 0; i < 150; i++) begin
      sym_code = 2'($urandom_range(0, 3));
      @(negedge clk);
      if (sym_ready !== 1'b1 || busy !== 1'b0 || tone_tick !== 1'b0 || tone_on !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL idle_hold bad_cycles=%0d want 0", bad);
    else n_pass++;
  endtask

  task automatic test_dot();
    play(2'b00, 0);
  endtask

  task automatic test_dash();
    play(2'b01, 0);
  endtask

  task automatic test_gaps_back_to_back();
    play(2'b10, 1);
    play(2'b11, 1);
  endtask

  task automatic test_code_change();
    play(2'b00, 1);
    play(2'b01, 2);
  endtask

  task automatic test_reset_mid(input int abort_at);
    sym_valid = 1'b1; sym_code = 2'b01;
    @(negedge clk);
    sym_valid = 1'b0;
    for (int i = 0; i < abort_at; i++) begin
      sym_code = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    n_checks++;
    if (tone_on !== (abort_at < 3 * UC))
      $display("FAIL pre_abort_tone at=%0d got %b want %b", abort_at, tone_on, abort_at < 3 * UC);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({tone_on, tone_tick, busy, sym_ready} !== 4'b0000)
      $display("FAIL abort_outputs at=%0d got tone/tick/busy/ready=%b want 0000",
               abort_at, {tone_on, tone_tick, busy, sym_ready});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (sym_ready !== 1'b1 || tone_tick !== 1'b0 || tone_on !== 1'b0)
      $display("FAIL abort_release at=%0d ready=%b tick=%b tone=%b want 1/0/0",
               abort_at, sym_ready, tone_tick, tone_on);
    else n_pass++;
  endtask

  task automatic test_random();
    int k;
    for (int n = 0; n < 14; n++) begin
      play(2'($urandom_range(0, 3)), $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(1, 5);
        repeat (k) @(negedge clk);
        n_checks++;
        if (sym_ready !== 1'b1 || busy !== 1'b0)
          $display("FAIL random_idle_gap ready=%b busy=%b want 1/0", sym_ready, busy);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_dot();
    test_dash();
    test_gaps_back_to_back();
    test_code_change();
    test_reset_mid(10);
    test_reset_mid($urandom_range(1, 78));
    test_random();
    test_dot();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
